llr_mem_writer: RTL and testbench

LLR_MEM_WRITER -- requirements
Module: llr_mem_writer

---
 rtl/llr_mem_writer.sv | 202 ++++++++++++++++++++
 tb/tb_llr_mem_writer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_mem_writer.sv
// llr_mem_writer: packs a stream of signed LLR beats into wide memory words.
// Each packet starts on a fresh word at address 1 upward. Address 0 receives a
// header word holding the packet count once the job completes. Writes that
// would land beyond the legal memory range are dropped, and a sticky overflow
// flag is raised instead.
module llr_mem_writer #(
  parameter int LANES    = 16,
  parameter int LLR_W    = 12,
  parameter int MEM_WORD = 1453,
  parameter int ADDRW    = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     module_en,
  input  logic [5:0]               pack_num,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LLR_W-1:0]         in_llr,
  input  logic                     in_last,
  output logic                     wen,
  output logic [ADDRW-1:0]         waddr,
  output logic [LANES*LLR_W-1:0]   wdata,
  output logic                     proc_done,
  output logic                     ovf
);

  localparam int WORD_W = LANES * LLR_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  // One spare bit so the word counter can run past the last legal address
  // without wrapping back onto low addresses during an overflow.
  localparam int CNT_W  = ADDRW + 1;
  localparam logic [CNT_W-1:0]  MEM_LIMIT = CNT_W'(MEM_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [2:0] {IDLE, FILL, FLUSH, HDR, DONE} state_t;

  state_t              state_q, state_d;
  logic                en_prev_q;
  logic [5:0]          pack_q, pack_d;
  logic [CNT_W-1:0]    addr_q, addr_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [5:0]          pkt_q, pkt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                wen_q, wen_d;
  logic [ADDRW-1:0]    waddr_q, waddr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  logic [WORD_W-1:0]   beat_word;
  logic [5:0]          pkt_inc;
  logic                en_rise;

  assign en_rise = module_en && !en_prev_q;
  assign pkt_inc = pkt_q + 6'd1;

  // Current word buffer with the incoming beat merged into the active lane.
  always_comb begin
    beat_word = word_q;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        beat_word[i*LLR_W +: LLR_W] = in_llr;
      end
    end
  end

  // Next-state, counters and registered write port.
  always_comb begin
    state_d   = state_q;
    pack_d    = pack_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    pkt_d     = pkt_q;
    word_d    = word_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (en_rise) begin
          pack_d = pack_num;
          addr_d = CNT_W'(1);
          lane_d = '0;
          pkt_d  = '0;
          word_d = '0;
          ovf_d  = 1'b0;
          if (pack_num == 6'd0) begin
            // Empty job: go straight to the header write.
            state_d      = HDR;
            wen_d        = 1'b1;
            waddr_d      = '0;
            wdata_d      = '0;
            wdata_d[5:0] = pack_num;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        if (!module_en) begin
          // Abort: drop the partial word, nothing more is written.
          state_d = IDLE;
          word_d  = '0;
          lane_d  = '0;
        end else if (in_valid) begin
          if ((lane_q == LAST_LANE) || in_last) begin
            if (addr_q < MEM_LIMIT) begin
              wen_d   = 1'b1;
              waddr_d = addr_q[ADDRW-1:0];
              wdata_d = beat_word;
            end else begin
              ovf_d = 1'b1;
            end
            word_d = '0;
            lane_d = '0;
            if (addr_q != {CNT_W{1'b1}}) begin
              addr_d = addr_q + 1'b1;
            end
            if (in_last) begin
              pkt_d = pkt_inc;
              if (pkt_inc == pack_q) begin
                state_d = FLUSH;
              end
            end
          end else begin
            word_d = beat_word;
            lane_d = lane_q + 1'b1;
          end
        end
      end

      FLUSH: begin
        // The final data word is on the write port during this cycle.
        if (!module_en) begin
          state_d = IDLE;
        end else begin
          state_d      = HDR;
          wen_d        = 1'b1;
          waddr_d      = '0;
          wdata_d      = '0;
          wdata_d[5:0] = pack_q;
        end
      end

      HDR: begin
        state_d = DONE;
        done_d  = 1'b1;
      end

      DONE: begin
        if (!module_en) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_prev_q <= 1'b0;
      pack_q    <= '0;
      addr_q    <= '0;
      lane_q    <= '0;
      pkt_q     <= '0;
      word_q    <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_prev_q <= module_en;
      pack_q    <= pack_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      pkt_q     <= pkt_d;
      word_q    <= word_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign wen       = wen_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign proc_done = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_llr_mem_writer.sv
// Testbench for llr_mem_writer: table of job vectors, hand sequences for
// abort and mid-job reset, and random jobs against a word-packing model.
`timescale 1ns/1ps
module tb_llr_mem_writer;
  localparam int LANES    = 16;
  localparam int LLR_W    = 12;
  localparam int MEM_WORD = 1453;
  localparam int ADDRW    = 11;
  localparam int WORD_W   = LANES * LLR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              module_en;
  logic [5:0]        pack_num;
  logic              in_valid;
  logic              in_ready;
  logic [LLR_W-1:0]  in_llr;
  logic              in_last;
  logic              wen;
  logic [ADDRW-1:0]  waddr;
  logic [WORD_W-1:0] wdata;
  logic              proc_done;
  logic              ovf;

  always #5 clk = ~clk;

  llr_mem_writer #(.LANES(LANES), .LLR_W(LLR_W), .MEM_WORD(MEM_WORD), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst_n(rst_n), .module_en(module_en), .pack_num(pack_num),
    .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr), .in_last(in_last),
    .wen(wen), .waddr(waddr), .wdata(wdata), .proc_done(proc_done), .ovf(ovf)
  );

  // Job vector: pack count, packet lengths, value pattern (0 seq, 1 all -1,
  // 2 random), valid pattern (0 continuous, 1 toggling, 2 random),
  // expected write count and overflow.
  typedef struct packed {
    logic [5:0]  pack;
    logic [2:0]  npk;
    logic [15:0] len0;
    logic [15:0] len1;
    logic [15:0] len2;
    logic [15:0] len3;
    logic [1:0]  vpat;
    logic [1:0]  gap;
    logic [15:0] exp_nw;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int failures = 0;

  // Monitor: record every write, proc_done pulse and ready cycle.
  int                mon_cyc = 0;
  logic [ADDRW-1:0]  m_addr[$];
  logic [WORD_W-1:0] m_data[$];
  int                m_wcyc[$];
  int                pd_total = 0;
  int                pd_last_cyc = 0;
  int                rdy_total = 0;

  always @(posedge clk) mon_cyc <= mon_cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wen) begin
        m_addr.push_back(waddr);
        m_data.push_back(wdata);
        m_wcyc.push_back(mon_cyc);
      end
      if (proc_done) begin
        pd_total    <= pd_total + 1;
        pd_last_cyc <= mon_cyc;
      end
      if (in_ready) rdy_total <= rdy_total + 1;
    end
  end

  // Stimulus and expectations.
  int                lens_q[$];
  logic [LLR_W-1:0]  beat_v[$];
  bit                beat_l[$];
  logic [ADDRW-1:0]  e_addr[$];
  logic [WORD_W-1:0] e_data[$];
  bit                e_ovf;
  int                base_w, base_pd, base_rdy;

  task automatic chk(input string what, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", what, got, exp);
    end
  endtask

  function automatic int pick_len(input vec_t v, input int p);
    case (p)
      0: return int'(v.len0);
      1: return int'(v.len1);
      2: return int'(v.len2);
      default: return int'(v.len3);
    endcase
  endfunction

  task automatic build_beats(input int vpat);
    int s = 1;
    beat_v.delete();
    beat_l.delete();
    foreach (lens_q[p]) begin
      for (int j = 0; j < lens_q[p]; j++) begin
        case (vpat)
          0: beat_v.push_back(LLR_W'(s));
          1: beat_v.push_back({LLR_W{1'b1}});
          default: beat_v.push_back(LLR_W'($urandom));
        endcase
        beat_l.push_back(j == lens_q[p] - 1);
        s++;
      end
    end
  endtask

  // Reference: each packet chopped into LANES-beat words, zero padded,
  // addresses from 1 upward, illegal addresses dropped; header last.
  task automatic model(input int pk);
    int addr = 1;
    int k = 0;
    int nw, idx;
    logic [WORD_W-1:0] d;
    e_addr.delete();
    e_data.delete();
    e_ovf = 0;
    foreach (lens_q[p]) begin
      nw = (lens_q[p] + LANES - 1) / LANES;
      for (int w = 0; w < nw; w++) begin
        d = '0;
        for (int l = 0; l < LANES; l++) begin
          idx = w * LANES + l;
          if (idx < lens_q[p]) d[l*LLR_W +: LLR_W] = beat_v[k + idx];
        end
        if (addr < MEM_WORD) begin
          e_addr.push_back(ADDRW'(addr));
          e_data.push_back(d);
        end else begin
          e_ovf = 1;
        end
        addr++;
      end
      k += lens_q[p];
    end
    d = '0;
    d[5:0] = 6'(pk);
    e_addr.push_back('0);
    e_data.push_back(d);
  endtask

  task automatic snap();
    base_w   = m_addr.size();
    base_pd  = pd_total;
    base_rdy = rdy_total;
  endtask

  task automatic drive(input int gap, input int count);
    int idx = 0;
    int cyc = 0;
    int limit;
    bit vld, acc;
    limit = count * 4 + 100;
    while (idx < count && cyc < limit) begin
      case (gap)
        0: vld = 1'b1;
        1: vld = (cyc % 2 == 0);
        default: vld = ($urandom_range(0, 1) == 1);
      endcase
      in_valid = vld;
      in_llr   = beat_v[idx];
      in_last  = beat_l[idx];
      @(negedge clk);
      acc = vld && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("beats_accepted", idx, count);
  endtask

  task automatic run_job(input int pk, input int gap);
    int n = 0;
    pack_num  = 6'(pk);
    module_en = 1'b1;
    drive(gap, beat_v.size());
    while (pd_total == base_pd && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    module_en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_job(input string name, input int exp_pd, input bit exp_rdy);
    int n, mis;
    n = m_addr.size() - base_w;
    chk({name, ".nwrites"}, n, e_addr.size());
    mis = -1;
    for (int i = 0; i < n && i < e_addr.size(); i++) begin
      if (mis < 0 && (m_addr[base_w+i] !== e_addr[i] || m_data[base_w+i] !== e_data[i])) mis = i;
    end
    checks++;
    if (mis >= 0) begin
      failures++;
      $display("FAIL %s.writes idx=%0d got addr=%0d data=%h required addr=%0d data=%h",
               name, mis, m_addr[base_w+mis], m_data[base_w+mis], e_addr[mis], e_data[mis]);
    end
    chk({name, ".ovf"}, ovf, e_ovf);
    chk({name, ".proc_done_cnt"}, pd_total - base_pd, exp_pd);
    if (exp_pd == 1 && n > 0) chk({name, ".hdr_to_done"}, pd_last_cyc - m_wcyc[base_w+n-1], 1);
    chk({name, ".ready_seen"}, (rdy_total != base_rdy), exp_rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pk;
    logic [ADDRW-1:0]  a0;
    logic [WORD_W-1:0] d0;
    string nm;

    vecs[0] = '{6'd1, 3'd1, 16'd32,    16'd0,  16'd0,  16'd0,  2'd0, 2'd0, 16'd3,    1'b0};
    vecs[1] = '{6'd2, 3'd2, 16'd5,     16'd16, 16'd0,  16'd0,  2'd2, 2'd0, 16'd3,    1'b0};
    vecs[2] = '{6'd0, 3'd0, 16'd0,     16'd0,  16'd0,  16'd0,  2'd0, 2'd0, 16'd1,    1'b0};
    vecs[3] = '{6'd1, 3'd1, 16'd16,    16'd0,  16'd0,  16'd0,  2'd1, 2'd1, 16'd2,    1'b0};
    vecs[4] = '{6'd3, 3'd3, 16'd1,     16'd17, 16'd33, 16'd0,  2'd2, 2'd2, 16'd7,    1'b0};
    vecs[5] = '{6'd4, 3'd4, 16'd15,    16'd16, 16'd31, 16'd48, 2'd2, 2'd0, 16'd8,    1'b0};
    vecs[6] = '{6'd1, 3'd1, 16'd23360, 16'd0,  16'd0,  16'd0,  2'd2, 2'd0, 16'd1453, 1'b1};

    rst_n = 1'b0; module_en = 1'b0; pack_num = '0;
    in_valid = 1'b0; in_llr = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.wen", wen, 0);
    chk("rst.waddr", waddr, 0);
    chk("rst.wdata_lo", wdata[63:0], 0);
    chk("rst.proc_done", proc_done, 0);
    chk("rst.ovf", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    for (int i = 0; i < 7; i++) begin
      nm = $sformatf("v%0d", i);
      lens_q.delete();
      for (int p = 0; p < int'(vecs[i].npk); p++) lens_q.push_back(pick_len(vecs[i], p));
      build_beats(int'(vecs[i].vpat));
      snap();
      model(int'(vecs[i].pack));
      run_job(int'(vecs[i].pack), int'(vecs[i].gap));
      check_job(nm, 1, vecs[i].pack != 0);
      n = m_addr.size() - base_w;
      chk({nm, ".table_nwrites"}, n, vecs[i].exp_nw);
      chk({nm, ".table_ovf"}, ovf, vecs[i].exp_ovf);
      if (i == 0 && n >= 2) chk("v0.no_bubble", m_wcyc[base_w+1] - m_wcyc[base_w], 16);
    end

    // Abort by dropping module_en after 20 beats of a 40-beat packet.
    lens_q.delete();
    lens_q.push_back(40);
    build_beats(0);
    snap();
    model(1);
    a0 = e_addr[0];
    d0 = e_data[0];
    e_addr.delete(); e_data.delete();
    e_addr.push_back(a0); e_data.push_back(d0);
    e_ovf = 0;
    pack_num = 6'd1; module_en = 1'b1;
    drive(0, 20);
    module_en = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check_job("abort", 0, 1);

    // Reset after 7 beats, then a fresh 16-beat job.
    lens_q.delete();
    lens_q.push_back(16);
    build_beats(2);
    snap();
    pack_num = 6'd1; module_en = 1'b1;
    drive(0, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", in_ready, 0);
    chk("midrst.wen", wen, 0);
    module_en = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    build_beats(2);
    model(1);
    run_job(1, 0);
    check_job("rst_job", 1, 1);

    // Random jobs.
    for (int r = 0; r < 6; r++) begin
      pk = $urandom_range(1, 4);
      lens_q.delete();
      for (int p = 0; p < pk; p++) lens_q.push_back($urandom_range(1, 40));
      build_beats(2);
      snap();
      model(pk);
      run_job(pk, 2);
      check_job($sformatf("rnd%0d", r), 1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
